uart_rx_frame: RTL and testbench

//  Serial-in UART receiver: 1 start bit, DBIT data bits (LSB first), 1 stop bit, no parity.
//  Rx is oversampled at 16x baud via the s_tick strobe from the shared baud-rate generator.

---
 rtl/uart_rx_frame_pkg.sv | 20 ++
 rtl/uart_rx_frame_sync_2ff.sv | 27 ++
 rtl/uart_rx_frame.sv | 125 ++++++++++++
 tb/tb_uart_rx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants.
package uart_rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

  // Tick counter must hold both OVERSAMPLE-1 and SB_TICK-1.
  function automatic int s_width(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? 5 : 4;
  endfunction

endpackage

// File: rtl/uart_rx_frame_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the line's
// idle level so a reset never looks like a start edge.
module uart_rx_frame_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 1 start, DBIT data (LSB first), 1 stop bit, 16x oversampled.
// Rejects start-bit glitches and reports framing errors and line breaks.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       break_det,
  output logic       rx_busy
);

  localparam int SW = s_width(SB_TICK);
  localparam logic [SW-1:0] S_MID  = SW'(START_MID);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  logic          rx_s;
  state_t        state_q, state_n;
  logic [SW-1:0] s_q, s_n;
  logic [2:0]    n_q, n_n;
  logic [7:0]    b_q, b_n;
  logic          frame_end;
  logic [7:0]    data_w;

  uart_rx_frame_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Data bits enter at the MSB, so a short frame ends up left-justified.
  assign data_w = b_q >> (8 - DBIT);

  always_comb begin
    state_n   = state_q;
    s_n       = s_q;
    n_n       = n_q;
    b_n       = b_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_n = '0;
            b_n = {rx_s, b_q[7:1]};
            if (n_q == N_LAST) state_n = STOP;
            else               n_n = n_q + 3'd1;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_n   = IDLE;
            frame_end = 1'b1;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Results are registered on the stop-bit sample, so they appear one clk later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state_q      <= state_n;
      s_q          <= s_n;
      n_q          <= n_n;
      b_q          <= b_n;
      rx_done_tick <= frame_end;
      rx_busy      <= (state_n != IDLE);
      if (frame_end) begin
        dout      <= data_w;
        frame_err <= ~rx_s;
        break_det <= ~rx_s & (data_w == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8-bit and a 7-bit receiver, each
// fed its own serial line; expected frames are queued as they are sent.
module tb_uart_rx_frame;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       brk;
  } exp_t;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] tcnt   = 2'd0;
  logic       rx8    = 1'b1;
  logic       rx7    = 1'b1;

  logic [7:0] dout8, dout7;
  logic       done8, done7, fe8, fe7, brk8, brk7, busy8, busy7;

  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;
  int   total = 0;
  int   bad   = 0;

  uart_rx_frame #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx8),
    .dout(dout8), .rx_done_tick(done8), .frame_err(fe8),
    .break_det(brk8), .rx_busy(busy8)
  );

  uart_rx_frame #(.DBIT(7), .SB_TICK(16)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
    .dout(dout7), .rx_done_tick(done7), .frame_err(fe7),
    .break_det(brk7), .rx_busy(busy7)
  );

  always #5 clk = ~clk;

  // One tick every 4 clks.
  always @(posedge clk) begin
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected frame result from the line-level rules.
  function automatic exp_t model(input logic [7:0] data, input int nbits, input bit stop_ok);
    exp_t e;
    e.d   = data & 8'((1 << nbits) - 1);
    e.fe  = !stop_ok;
    e.brk = !stop_ok && (e.d == 8'd0);
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!s_tick);
    end
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 7) rx7 = v;
    else            rx8 = v;
  endtask

  // A low stop bit is held only past its sample point, so the line is high
  // again before the restarted start-bit check and no phantom frame follows.
  task automatic send_frame(input int which, input logic [7:0] data, input bit stop_ok);
    int nbits;
    nbits = (which == 7) ? 7 : 8;
    if (which == 7) q7.push_back(model(data, 7, stop_ok));
    else            q8.push_back(model(data, 8, stop_ok));
    drive(which, 1'b0);
    wait_ticks(16);
    for (int k = 0; k < nbits; k++) begin
      drive(which, data[k]);
      wait_ticks(16);
    end
    if (stop_ok) begin
      drive(which, 1'b1);
      wait_ticks(16);
    end else begin
      drive(which, 1'b0);
      wait_ticks(10);
      drive(which, 1'b1);
      wait_ticks(6);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("dut8 unexpected pulse", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("dut8 dout", 32'(dout8), 32'(e8.d));
        check("dut8 frame_err", 32'(fe8), 32'(e8.fe));
        check("dut8 break_det", 32'(brk8), 32'(e8.brk));
        check("dut8 busy at done", 32'(busy8), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done7) begin
      if (q7.size() == 0) begin
        check("dut7 unexpected pulse", 32'd1, 32'd0);
      end else begin
        e7 = q7.pop_front();
        check("dut7 dout", 32'(dout7), 32'(e7.d));
        check("dut7 frame_err", 32'(fe7), 32'(e7.fe));
        check("dut7 break_det", 32'(brk7), 32'(e7.brk));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d2;
    logic [7:0] rd;
    int         which;
    bit         ok;
    int         hold;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset dout8", 32'(dout8), 32'd0);
    check("reset done8", 32'(done8), 32'd0);
    check("reset fe8", 32'(fe8), 32'd0);
    check("reset brk8", 32'(brk8), 32'd0);
    check("reset busy8", 32'(busy8), 32'd0);
    check("reset dout7", 32'(dout7), 32'd0);
    check("reset busy7", 32'(busy7), 32'd0);
    reset = 1'b0;
    wait_ticks(40);

    // Good frame.
    send_frame(8, 8'hA5, 1'b1);
    wait_ticks(16);
    check("busy after A5", 32'(busy8), 32'd0);
    check("A5 holds", 32'(dout8), 32'hA5);

    // Start-bit glitch.
    drive(8, 1'b0);
    wait_ticks(4);
    check("busy during glitch", 32'(busy8), 32'd1);
    drive(8, 1'b1);
    wait_ticks(6);
    check("busy after glitch", 32'(busy8), 32'd0);
    check("dout after glitch", 32'(dout8), 32'hA5);
    wait_ticks(32);

    // Low stop bit.
    send_frame(8, 8'h3C, 1'b0);
    wait_ticks(32);

    // Held-low break of 12 bit-times. The first frame is a break; the frame
    // restarted by the still-low line samples bit k 176+16k ticks after the
    // fall, so bits sampled while the line is still low read 0.
    hold = 192;
    q8.push_back(model(8'h00, 8, 1'b0));
    for (int k = 0; k < 8; k++) d2[k] = ((176 + 16 * k) > hold);
    q8.push_back(model(d2, 8, 1'b1));
    drive(8, 1'b0);
    wait_ticks(hold);
    drive(8, 1'b1);
    wait_ticks(200);

    // Back-to-back frames.
    send_frame(8, 8'h00, 1'b1);
    send_frame(8, 8'hFF, 1'b1);
    wait_ticks(32);

    // Reset during data bit 3 of 0x81.
    rd = 8'h81;
    drive(8, 1'b0);
    wait_ticks(16);
    for (int k = 0; k < 3; k++) begin
      drive(8, rd[k]);
      wait_ticks(16);
    end
    drive(8, rd[3]);
    wait_ticks(8);
    check("busy mid-frame", 32'(busy8), 32'd1);
    reset = 1'b1;
    drive(8, 1'b1);
    @(posedge clk);
    #1;
    check("mid reset dout8", 32'(dout8), 32'd0);
    check("mid reset fe8", 32'(fe8), 32'd0);
    check("mid reset brk8", 32'(brk8), 32'd0);
    check("mid reset busy8", 32'(busy8), 32'd0);
    check("mid reset done8", 32'(done8), 32'd0);
    reset = 1'b0;
    wait_ticks(32);
    send_frame(8, 8'h81, 1'b1);
    wait_ticks(32);

    // Seven data bits.
    send_frame(7, 8'h55, 1'b1);
    wait_ticks(32);
    check("dut7 bit7 clear", 32'(dout7[7]), 32'd0);

    // Randomized frames on both receivers.
    for (int i = 0; i < 24; i++) begin
      which = ($urandom_range(0, 3) == 0) ? 7 : 8;
      rd    = 8'($urandom);
      ok    = ($urandom_range(0, 3) != 0);
      send_frame(which, rd, ok);
      wait_ticks(8 * $urandom_range(0, 2));
    end
    wait_ticks(64);

    check("dut8 frames outstanding", 32'(q8.size()), 32'd0);
    check("dut7 frames outstanding", 32'(q7.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
